// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared types and constants for the decode / inverse-transform back end
//
// Contents:
//   seg_t          - image segment of a block (Y, U, V)
//   sched_state_t  - block_pipeline_scheduler state encoding
//   BLOCK_8X8 / BLOCK_16X16 - block_mode values
//   POS_ROW_W / POS_COL_W   - widths of the block row/column position fields
package decoder_pkg;

   typedef enum logic [1:0] {
      SEG_Y = 2'd0,
      SEG_U = 2'd1,
      SEG_V = 2'd2
   } seg_t;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FILL    = 3'd1,
      S_OVERLAP = 3'd2,
      S_DRAIN   = 3'd3,
      S_DONE    = 3'd4
   } sched_state_t;

   localparam logic BLOCK_8X8   = 1'b0;
   localparam logic BLOCK_16X16 = 1'b1;

   localparam int POS_ROW_W = 5;
   localparam int POS_COL_W = 6;

endpackage

// File: rtl/block_position_counter.sv
// rtl/block_position_counter.sv - row-major Y/U/V block position walker
//
// Ports:
//   Clock_50   in  : system clock
//   Resetn     in  : synchronous active-low reset
//   mode       in  : latched block mode (BLOCK_8X8 / BLOCK_16X16)
//   clear      in  : return to Y (0,0)
//   advance    in  : step to the next block in traversal order
//   seg        out : current segment
//   brow       out : block row within the segment
//   bcol       out : block column within the segment
//   last_block out : current position is the final block of V
module block_position_counter
   import decoder_pkg::*;
#(
   parameter int Y_COLS8 = 40,
   parameter int Y_ROWS8 = 30
) (
   input  logic                 Clock_50,
   input  logic                 Resetn,
   input  logic                 mode,
   input  logic                 clear,
   input  logic                 advance,
   output seg_t                 seg,
   output logic [POS_ROW_W-1:0] brow,
   output logic [POS_COL_W-1:0] bcol,
   output logic                 last_block
);

   // Chroma segments are half the luma width and full luma height;
   // 16x16 mode halves every dimension again.
   localparam logic [POS_COL_W-1:0] Y_COL_LAST_8  = POS_COL_W'(Y_COLS8 - 1);
   localparam logic [POS_COL_W-1:0] C_COL_LAST_8  = POS_COL_W'(Y_COLS8 / 2 - 1);
   localparam logic [POS_ROW_W-1:0] ROW_LAST_8    = POS_ROW_W'(Y_ROWS8 - 1);
   localparam logic [POS_COL_W-1:0] Y_COL_LAST_16 = POS_COL_W'(Y_COLS8 / 2 - 1);
   localparam logic [POS_COL_W-1:0] C_COL_LAST_16 = POS_COL_W'(Y_COLS8 / 4 - 1);
   localparam logic [POS_ROW_W-1:0] ROW_LAST_16   = POS_ROW_W'(Y_ROWS8 / 2 - 1);

   logic [POS_COL_W-1:0] col_last;
   logic [POS_ROW_W-1:0] row_last;
   logic                 at_last_col;
   logic                 at_last_row;

   always_comb begin
      col_last = (seg == SEG_Y) ? Y_COL_LAST_8 : C_COL_LAST_8;
      row_last = ROW_LAST_8;
      if (mode == BLOCK_16X16) begin
         col_last = (seg == SEG_Y) ? Y_COL_LAST_16 : C_COL_LAST_16;
         row_last = ROW_LAST_16;
      end
   end

   assign at_last_col = (bcol == col_last);
   assign at_last_row = (brow == row_last);
   assign last_block  = at_last_col && at_last_row && (seg == SEG_V);

   always_ff @(posedge Clock_50) begin
      if (!Resetn || clear) begin
         seg  <= SEG_Y;
         brow <= '0;
         bcol <= '0;
      end else if (advance && !last_block) begin
         if (!at_last_col) begin
            bcol <= bcol + POS_COL_W'(1);
         end else begin
            bcol <= '0;
            if (!at_last_row) begin
               brow <= brow + POS_ROW_W'(1);
            end else begin
               brow <= '0;
               seg  <= (seg == SEG_Y) ? SEG_U : SEG_V;
            end
         end
      end
   end

endmodule

// File: rtl/block_pipeline_scheduler.sv
// rtl/block_pipeline_scheduler.sv - ping-pong M3/M2 block sequencer for a full image pass
//
// Ports:
//   Clock_50     in  : system clock
//   Resetn       in  : synchronous active-low reset
//   start        in  : begin a full-image pass (ignored while busy)
//   block_mode   in  : 0 = 8x8, 1 = 16x16, sampled on accepted start
//   block_mode_o out : latched mode for M3/M2
//   m3_start     out : pulse, M3 decodes next block
//   m3_finish    in  : pulse from M3
//   m2_start     out : pulse, M2 transforms current block
//   m2_finish    in  : pulse from M2
//   m2_seg       out : segment of M2's block (0 Y, 1 U, 2 V)
//   m2_brow      out : block row of M2's block
//   m2_bcol      out : block column of M2's block
//   busy         out : pass in progress
//   done         out : pulse at pass completion
module block_pipeline_scheduler
   import decoder_pkg::*;
#(
   parameter int Y_COLS8 = 40,
   parameter int Y_ROWS8 = 30
) (
   input  logic                 Clock_50,
   input  logic                 Resetn,
   input  logic                 start,
   input  logic                 block_mode,
   output logic                 block_mode_o,
   output logic                 m3_start,
   input  logic                 m3_finish,
   output logic                 m2_start,
   input  logic                 m2_finish,
   output logic [1:0]           m2_seg,
   output logic [POS_ROW_W-1:0] m2_brow,
   output logic [POS_COL_W-1:0] m2_bcol,
   output logic                 busy,
   output logic                 done
);

   // Y + U + V, where U and V are each half of Y.
   localparam int TOTAL_8  = 2 * Y_COLS8 * Y_ROWS8;
   localparam int TOTAL_16 = (Y_COLS8 / 2) * (Y_ROWS8 / 2) + 2 * (Y_COLS8 / 4) * (Y_ROWS8 / 2);
   // Wide enough to hold the 8x8 block total of the configured geometry.
   localparam int CNT_W    = $clog2(TOTAL_8 + 1);

   sched_state_t     state, state_n;
   logic             mode_n, busy_n, done_n, m3_start_n, m2_start_n;
   logic             m3_done, m2_done, m3_done_n, m2_done_n;
   logic             m3_seen, m2_seen;
   logic [CNT_W-1:0] m3_cnt, cnt_n, total;
   logic             pos_clear, pos_advance, last_block;
   seg_t             pos_seg;

   assign total  = (block_mode_o == BLOCK_16X16) ? CNT_W'(TOTAL_16) : CNT_W'(TOTAL_8);
   assign m2_seg = pos_seg;

   // The position register always describes the block M2 was last started
   // on: it is cleared with the first m3_start (so block 0 is ready for the
   // first m2_start) and advanced in the same cycle as every later m2_start.
   block_position_counter #(
      .Y_COLS8 (Y_COLS8),
      .Y_ROWS8 (Y_ROWS8)
   ) u_pos (
      .Clock_50   (Clock_50),
      .Resetn     (Resetn),
      .mode       (block_mode_o),
      .clear      (pos_clear),
      .advance    (pos_advance),
      .seg        (pos_seg),
      .brow       (m2_brow),
      .bcol       (m2_bcol),
      .last_block (last_block)
   );

   always_ff @(posedge Clock_50) begin
      if (!Resetn) begin
         state        <= S_IDLE;
         block_mode_o <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         m3_start     <= 1'b0;
         m2_start     <= 1'b0;
         m3_done      <= 1'b0;
         m2_done      <= 1'b0;
         m3_cnt       <= '0;
      end else begin
         state        <= state_n;
         block_mode_o <= mode_n;
         busy         <= busy_n;
         done         <= done_n;
         m3_start     <= m3_start_n;
         m2_start     <= m2_start_n;
         m3_done      <= m3_done_n;
         m2_done      <= m2_done_n;
         m3_cnt       <= cnt_n;
      end
   end

   always_comb begin
      state_n     = state;
      mode_n      = block_mode_o;
      busy_n      = busy;
      done_n      = 1'b0;
      m3_start_n  = 1'b0;
      m2_start_n  = 1'b0;
      m3_done_n   = m3_done;
      m2_done_n   = m2_done;
      cnt_n       = m3_cnt;
      pos_clear   = 1'b0;
      pos_advance = 1'b0;
      m3_seen     = m3_done || m3_finish;
      m2_seen     = m2_done || m2_finish;

      case (state)
         S_IDLE: begin
            if (start) begin
               mode_n     = block_mode;
               pos_clear  = 1'b1;
               m3_done_n  = 1'b0;
               m2_done_n  = 1'b0;
               cnt_n      = CNT_W'(1);
               m3_start_n = 1'b1;
               busy_n     = 1'b1;
               state_n    = S_FILL;
            end
         end

         S_FILL: begin
            // Still at position 0 here, so last_block means a one-block image.
            // M2 is started on it either way, otherwise the drain would never end.
            if (m3_finish) begin
               m2_start_n = 1'b1;
               if (last_block) begin
                  state_n = S_DRAIN;
               end else begin
                  m3_start_n = 1'b1;
                  cnt_n      = m3_cnt + CNT_W'(1);
                  state_n    = S_OVERLAP;
               end
            end
         end

         S_OVERLAP: begin
            // A new m3_start would overwrite the buffer M2 is reading, so
            // both units must have finished before either is restarted.
            if (m3_seen && m2_seen) begin
               m3_done_n   = 1'b0;
               m2_done_n   = 1'b0;
               pos_advance = 1'b1;
               m2_start_n  = 1'b1;
               if (m3_cnt == total) begin
                  state_n = S_DRAIN;
               end else begin
                  m3_start_n = 1'b1;
                  cnt_n      = m3_cnt + CNT_W'(1);
               end
            end else begin
               m3_done_n = m3_seen;
               m2_done_n = m2_seen;
            end
         end

         S_DRAIN: begin
            if (m2_finish) begin
               done_n  = 1'b1;
               busy_n  = 1'b0;
               state_n = S_DONE;
            end
         end

         S_DONE: begin
            state_n = S_IDLE;
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_block_pipeline_scheduler.sv
// tb/tb_block_pipeline_scheduler.sv - self-checking bench for block_pipeline_scheduler
module tb_block_pipeline_scheduler;

   localparam int C = 4;
   localparam int R = 2;

   logic       Clock_50 = 1'b0;
   logic       Resetn = 1'b0;
   logic       start = 1'b0;
   logic       block_mode = 1'b0;
   logic       block_mode_o, m3_start, m2_start, busy, done;
   logic       m3_finish, m2_finish;
   logic [1:0] m2_seg;
   logic [4:0] m2_brow;
   logic [5:0] m2_bcol;

   logic m3_fin_r = 1'b0;
   logic m2_fin_r = 1'b0;
   logic spur_m2  = 1'b0;
   assign m3_finish = m3_fin_r;
   assign m2_finish = m2_fin_r | spur_m2;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int lat_mode = 0;
   int m3_cd = 0;
   int m2_cd = 0;
   int viol = 0;
   logic busy_prev = 1'b0;

   int q_start[$], q_m3s[$], q_m2s[$], q_pos[$], q_m3f[$], q_m2f[$], q_done[$], q_brise[$];
   int b_start, b_m3s, b_m2s, b_m3f, b_m2f, b_done, b_brise;

   always #10 Clock_50 = ~Clock_50;

   block_pipeline_scheduler #(
      .Y_COLS8 (C),
      .Y_ROWS8 (R)
   ) dut (
      .Clock_50     (Clock_50),
      .Resetn       (Resetn),
      .start        (start),
      .block_mode   (block_mode),
      .block_mode_o (block_mode_o),
      .m3_start     (m3_start),
      .m3_finish    (m3_finish),
      .m2_start     (m2_start),
      .m2_finish    (m2_finish),
      .m2_seg       (m2_seg),
      .m2_brow      (m2_brow),
      .m2_bcol      (m2_bcol),
      .busy         (busy),
      .done         (done)
   );

   function automatic int pick_lat(input bit is_m3, input int k);
      case (lat_mode)
         0:       return is_m3 ? 5 : 8;
         1:       return 6;
         2:       return (k % 2 == 1) ? 9 : 3;
         default: return is_m3 ? int'($urandom_range(10, 4)) : int'($urandom_range(10, 1));
      endcase
   endfunction

   // Monitor and M3/M2 latency models, all on the falling edge.
   always @(negedge Clock_50) begin
      cyc++;
      if (start) q_start.push_back(cyc);
      if (m3_start) q_m3s.push_back(cyc);
      if (m2_start) begin
         q_m2s.push_back(cyc);
         q_pos.push_back(int'(m2_seg) * 4096 + int'(m2_brow) * 64 + int'(m2_bcol));
      end
      if (done) q_done.push_back(cyc);
      if (busy && !busy_prev) q_brise.push_back(cyc);
      busy_prev = busy;
      if ((q_m3s.size() - b_m3s) > (q_m2f.size() - b_m2f) + 2) viol++;

      m3_fin_r = 1'b0;
      m2_fin_r = 1'b0;
      if (!Resetn) begin
         m3_cd = 0;
         m2_cd = 0;
      end else begin
         if (m3_cd == 1) begin
            m3_fin_r = 1'b1;
            q_m3f.push_back(cyc);
         end
         if (m3_cd > 0) m3_cd--;
         if (m2_cd == 1) begin
            m2_fin_r = 1'b1;
            q_m2f.push_back(cyc);
         end
         if (m2_cd > 0) m2_cd--;
         if (m3_start) m3_cd = pick_lat(1'b1, q_m3s.size() - b_m3s - 1);
         if (m2_start) m2_cd = pick_lat(1'b0, q_m2s.size() - b_m2s - 1);
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic mark_bases();
      b_start = q_start.size();
      b_m3s   = q_m3s.size();
      b_m2s   = q_m2s.size();
      b_m3f   = q_m3f.size();
      b_m2f   = q_m2f.size();
      b_done  = q_done.size();
      b_brise = q_brise.size();
   endtask

   task automatic run_pass(input string name, input logic mode, input int lm,
                           input int extra_start_at, input int spur_at);
      int  k;
      bit  timed_out;
      int  viol0;
      int  exp_pos[$];
      int  n, cols, rows, e, f, a;
      lat_mode = lm;
      mark_bases();
      viol0 = viol;
      @(posedge Clock_50); #1;
      block_mode = mode;
      start = 1'b1;
      @(posedge Clock_50); #1;
      start = 1'b0;
      block_mode = ~mode;
      k = 1;
      timed_out = 1'b1;
      while (k < 3000) begin
         if (k == extra_start_at) start = 1'b1;
         if (k == spur_at) spur_m2 = 1'b1;
         @(posedge Clock_50); #1;
         start = 1'b0;
         spur_m2 = 1'b0;
         k++;
         if (q_done.size() > b_done) begin
            timed_out = 1'b0;
            break;
         end
      end
      repeat (5) @(posedge Clock_50);
      #1;
      chk({name, " timeout"}, int'(timed_out), 0);

      // Reference traversal: row-major, Y then U then V.
      for (int s = 0; s < 3; s++) begin
         cols = (s == 0) ? C : C / 2;
         rows = R;
         if (mode) begin
            cols = cols / 2;
            rows = rows / 2;
         end
         for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++)
               exp_pos.push_back(s * 4096 + r * 64 + c);
      end
      n = exp_pos.size();

      chk({name, " m3_start count"}, q_m3s.size() - b_m3s, n);
      chk({name, " m2_start count"}, q_m2s.size() - b_m2s, n);
      chk({name, " done count"}, q_done.size() - b_done, 1);
      chk({name, " m3 ahead limit"}, viol - viol0, 0);
      chk({name, " busy after"}, int'(busy), 0);
      chk({name, " mode latched"}, int'(block_mode_o), int'(mode));
      if (q_brise.size() > b_brise)
         chk({name, " busy rise"}, q_brise[b_brise], q_start[b_start] + 1);
      else
         chk({name, " busy rise seen"}, 0, 1);

      if (q_m3s.size() - b_m3s == n && q_m2s.size() - b_m2s == n &&
          q_m3f.size() - b_m3f == n && q_m2f.size() - b_m2f == n) begin
         for (int i = 0; i < n; i++) begin
            chk($sformatf("%s pos[%0d]", name, i), q_pos[b_m2s + i], exp_pos[i]);
            // m3_start i: after accepted start, or after M3 finish i-1 and M2 finish i-2.
            if (i == 0) e = q_start[b_start] + 1;
            else begin
               f = q_m3f[b_m3f + i - 1];
               a = (i >= 2) ? q_m2f[b_m2f + i - 2] : 0;
               e = ((f > a) ? f : a) + 1;
            end
            chk($sformatf("%s m3_start_t[%0d]", name, i), q_m3s[b_m3s + i], e);
            // m2_start i: after M3 finish i and M2 finish i-1.
            f = q_m3f[b_m3f + i];
            a = (i >= 1) ? q_m2f[b_m2f + i - 1] : 0;
            e = ((f > a) ? f : a) + 1;
            chk($sformatf("%s m2_start_t[%0d]", name, i), q_m2s[b_m2s + i], e);
         end
         if (q_done.size() > b_done)
            chk({name, " done_t"}, q_done[b_done], q_m2f[b_m2f + n - 1] + 1);
      end
   endtask

   task automatic chk_outputs_zero(input string name);
      chk({name, " busy"}, int'(busy), 0);
      chk({name, " done"}, int'(done), 0);
      chk({name, " m3_start"}, int'(m3_start), 0);
      chk({name, " m2_start"}, int'(m2_start), 0);
      chk({name, " m2_seg"}, int'(m2_seg), 0);
      chk({name, " m2_brow"}, int'(m2_brow), 0);
      chk({name, " m2_bcol"}, int'(m2_bcol), 0);
      chk({name, " block_mode_o"}, int'(block_mode_o), 0);
      chk({name, " state"}, int'(dut.state), int'(decoder_pkg::S_IDLE));
   endtask

   initial begin
      int m3s_at_reset;
      mark_bases();
      repeat (3) @(posedge Clock_50);
      #1;
      chk_outputs_zero("reset");
      Resetn = 1'b1;

      run_pass("8x8_m3_5_m2_8", 1'b0, 0, 0, 0);
      run_pass("16x16_m3_5_m2_8", 1'b1, 0, 0, 0);
      run_pass("simultaneous", 1'b0, 1, 0, 0);
      run_pass("alternating", 1'b0, 2, 0, 0);
      run_pass("restart_spurious", 1'b0, 3, 40, 2);
      run_pass("random_16x16", 1'b1, 3, 0, 0);

      // Abort mid-pass.
      lat_mode = 3;
      mark_bases();
      @(posedge Clock_50); #1;
      block_mode = 1'b1;
      start = 1'b1;
      @(posedge Clock_50); #1;
      start = 1'b0;
      repeat (30) @(posedge Clock_50);
      #1;
      chk("abort busy before reset", int'(busy), 1);
      Resetn = 1'b0;
      @(posedge Clock_50); #1;
      chk_outputs_zero("abort");
      m3s_at_reset = q_m3s.size();
      Resetn = 1'b1;
      repeat (20) @(posedge Clock_50);
      #1;
      chk("abort no further m3_start", q_m3s.size() - m3s_at_reset, 0);

      run_pass("after_abort", 1'($urandom_range(1, 0)), 3, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
